// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for debug/loader, data load/store and instruction fetch.
// One transaction in flight: grant (IDLE/RESP) -> ACCESS -> RESP, with fetch anti-starvation.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dbg_req,
  input  logic              dat_req,
  input  logic              ift_req,
  input  logic              dbg_we,
  input  logic              dat_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [ADDR_W-1:0] dat_addr,
  input  logic [ADDR_W-1:0] ift_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [DATA_W-1:0] dat_wdata,
  output logic              dbg_gnt,
  output logic              dat_gnt,
  output logic              ift_gnt,
  output logic              dbg_rvalid,
  output logic              dat_rvalid,
  output logic              ift_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DBG  = 2'd1;
  localparam logic [1:0] OWN_DAT  = 2'd2;
  localparam logic [1:0] OWN_IFT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [WAIT_W-1:0]   ift_wait;
  logic [WAIT_W-1:0]   ift_wait_d;
  logic                gnt_ok;
  logic                ift_promote;
  logic                any_gnt;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we;
  logic [1:0]          sel_owner;
  logic [ADDR_W-1:0]   addr_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic                we_p1;
  logic [1:0]          owner_p1;
  logic                vld_p1;
  logic                vld_p2;

  function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
    return (v >= WAIT_SAT) ? WAIT_SAT : v + WAIT_W'(1);
  endfunction

  assign gnt_ok      = (state_q == IDLE) || (state_q == RESP);
  assign ift_promote = (ift_wait == WAIT_SAT);
  assign any_gnt     = dbg_gnt || dat_gnt || ift_gnt;

  // Grant stage: fixed priority, fetch jumps ahead of data once it has waited long enough
  always_comb begin
    dbg_gnt   = 1'b0;
    dat_gnt   = 1'b0;
    ift_gnt   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_owner = OWN_NONE;
    if (gnt_ok) begin
      if (dbg_req) begin
        dbg_gnt   = 1'b1;
        sel_addr  = dbg_addr;
        sel_wdata = dbg_wdata;
        sel_we    = dbg_we;
        sel_owner = OWN_DBG;
      end else if (ift_promote && ift_req) begin
        ift_gnt   = 1'b1;
        sel_addr  = ift_addr;
        sel_owner = OWN_IFT;
      end else if (dat_req) begin
        dat_gnt   = 1'b1;
        sel_addr  = dat_addr;
        sel_wdata = dat_wdata;
        sel_we    = dat_we;
        sel_owner = OWN_DAT;
      end else if (ift_req) begin
        ift_gnt   = 1'b1;
        sel_addr  = ift_addr;
        sel_owner = OWN_IFT;
      end
    end

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_gnt ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = any_gnt ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase

    ift_wait_d = (ift_req && !ift_gnt) ? wait_sat_inc(ift_wait) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ift_wait <= '0;
    end else begin
      state_q  <= state_d;
      ift_wait <= ift_wait_d;
    end
  end

  // Access stage registers: request captured at the grant edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_p1  <= '0;
      wdata_p1 <= '0;
      we_p1    <= 1'b0;
      owner_p1 <= OWN_NONE;
    end else if (any_gnt) begin
      addr_p1  <= sel_addr;
      wdata_p1 <= sel_wdata;
      we_p1    <= sel_we;
      owner_p1 <= sel_owner;
    end else if (state_q == RESP) begin
      owner_p1 <= OWN_NONE;
    end
  end

  assign vld_p1    = (state_q == ACCESS);
  assign mem_addr  = addr_p1;
  assign mem_wdata = wdata_p1;
  assign mem_we    = vld_p1 && we_p1;
  assign owner     = owner_p1;

  // Response stage: memory has registered the read, route it to the owner
  assign vld_p2     = (state_q == RESP);
  assign rdata      = vld_p2 ? mem_rdata : '0;
  assign dbg_rvalid = vld_p2 && (owner_p1 == OWN_DBG);
  assign dat_rvalid = vld_p2 && (owner_p1 == OWN_DAT);
  assign ift_rvalid = vld_p2 && (owner_p1 == OWN_IFT);

endmodule
